// File: rtl/uart_rom_loader.sv
// uart_rom_loader: UART receiver that writes a length-prefixed little-endian word image into ROM.
// Ports: clk, rst (async, active-high), uart_rxd (serial in, idle high);
//        rom_w_en_o/rom_w_addr_o/rom_w_data_o (ROM write port);
//        load_busy_o, load_done_o, frame_err_o, chk_err_o (status).
// Optional: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_rom_loader #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rxd,
    output logic        rom_w_en_o,
    output logic [31:0] rom_w_addr_o,
    output logic [31:0] rom_w_data_o,
    output logic        load_busy_o,
    output logic        load_done_o,
    output logic        frame_err_o,
    output logic        chk_err_o
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {LD_LEN_LO, LD_LEN_HI, LD_WORD, LD_CHK, LD_DONE} ld_state_t;
    localparam ld_state_t LD_END = LD_CHK;
    logic [7:0] chk_q, chk_d;
    logic       chk_err_q, chk_err_d;
`else
    typedef enum logic [2:0] {LD_LEN_LO, LD_LEN_HI, LD_WORD, LD_DONE} ld_state_t;
    localparam ld_state_t LD_END = LD_DONE;
`endif
    rx_state_t      rx_state_q, rx_state_d;
    logic [1:0]     sync_q, sync_d;
    logic           prev_q, prev_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           byte_valid_q, byte_valid_d;
    logic           frame_err_q, frame_err_d;
    ld_state_t      ld_state_q, ld_state_d;
    logic [15:0]    len_q, len_d, word_cnt_q, word_cnt_d;
    logic [1:0]     byte_idx_q, byte_idx_d;
    logic [31:0]    asm_q, asm_d, addr_q, addr_d, data_q, data_d;
    logic           w_en_q, w_en_d;

    always_comb begin
        sync_d       = {sync_q[0], uart_rxd};
        prev_d       = sync_q[1];
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = frame_err_q;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync_q[1]) rx_state_d = RX_START;
            end
            RX_START: if (cnt_q == HALF) begin
                cnt_d      = '0;
                bit_cnt_d  = '0;
                rx_state_d = sync_q[1] ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == FULL) begin
                cnt_d     = '0;
                shift_d   = {sync_q[1], shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
            end
            default: if (cnt_q == FULL) begin
                cnt_d        = '0;
                rx_state_d   = RX_IDLE;
                byte_valid_d = sync_q[1];
                frame_err_d  = frame_err_q | !sync_q[1];
            end
        endcase
    end

    // shift_q stays stable after the stop bit, so it serves as the received byte.
    always_comb begin
        ld_state_d = ld_state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        addr_d     = w_en_q ? addr_q + 32'd4 : addr_q;
        w_en_d     = 1'b0;
        data_d     = data_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d      = chk_q;
        chk_err_d  = chk_err_q;
`endif
        if (byte_valid_q) begin
            case (ld_state_q)
                LD_LEN_LO: begin
                    len_d[7:0] = shift_q;
                    ld_state_d = LD_LEN_HI;
                end
                LD_LEN_HI: begin
                    len_d[15:8] = shift_q;
                    ld_state_d  = ({shift_q, len_q[7:0]} == 16'd0) ? LD_END : LD_WORD;
                end
                LD_WORD: begin
                    asm_d      = {shift_q, asm_q[31:8]};
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d      = chk_q ^ shift_q;
`endif
                    if (byte_idx_q == 2'd3) begin
                        w_en_d     = 1'b1;
                        data_d     = {shift_q, asm_q[31:8]};
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (word_cnt_q + 16'd1 == len_q) ld_state_d = LD_END;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                LD_CHK: begin
                    chk_err_d  = shift_q != chk_q;
                    ld_state_d = LD_DONE;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= 2'b11;
            prev_q       <= 1'b1;
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ld_state_q   <= LD_LEN_LO;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            w_en_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q        <= '0;
            chk_err_q    <= 1'b0;
`endif
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            ld_state_q   <= ld_state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            w_en_q       <= w_en_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q        <= chk_d;
            chk_err_q    <= chk_err_d;
`endif
        end
    end

    assign rom_w_en_o   = w_en_q;
    assign rom_w_addr_o = addr_q;
    assign rom_w_data_o = data_q;
    assign load_done_o  = ld_state_q == LD_DONE;
    assign load_busy_o  = !load_done_o;
    assign frame_err_o  = frame_err_q;
`ifdef LOADER_CHECKSUM_EN
    assign chk_err_o    = chk_err_q;
`else
    assign chk_err_o    = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rom_loader.sv
// tb_uart_rom_loader: randomized and directed bench for uart_rom_loader against a byte-stream model.
module tb_uart_rom_loader;
    localparam int DIV = 10;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rxd = 1'b1;
    logic        rom_w_en_o;
    logic [31:0] rom_w_addr_o, rom_w_data_o;
    logic        load_busy_o, load_done_o, frame_err_o, chk_err_o;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [63:0] wr_q[$];
    logic [7:0]  good_q[$];
    logic [7:0]  stream_q[$];
    logic        bad_sent = 1'b0;
    logic        prev_en = 1'b0;

    always #5 clk = ~clk;

    uart_rom_loader #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
        .clk(clk), .rst(rst), .uart_rxd(uart_rxd),
        .rom_w_en_o(rom_w_en_o), .rom_w_addr_o(rom_w_addr_o), .rom_w_data_o(rom_w_data_o),
        .load_busy_o(load_busy_o), .load_done_o(load_done_o),
        .frame_err_o(frame_err_o), .chk_err_o(chk_err_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rom_w_en_o) begin
            check("no_back_to_back", {63'd0, prev_en}, 64'd0);
            wr_q.push_back({rom_w_addr_o, rom_w_data_o});
        end
        prev_en = rom_w_en_o;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        uart_rxd = 1'b0;
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (DIV) @(posedge clk);
        end
        uart_rxd = stop_ok;
        repeat (DIV) @(posedge clk);
        uart_rxd = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        if (stop_ok) good_q.push_back(b);
        else bad_sent = 1'b1;
    endtask

    task automatic send_stream();
        foreach (stream_q[i]) send_byte(stream_q[i], 1'b1);
        stream_q.delete();
    endtask

    task automatic do_reset(input logic chk_vals);
        rst = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (chk_vals) begin
            check("rst_w_en", {63'd0, rom_w_en_o}, 64'd0);
            check("rst_addr", {32'd0, rom_w_addr_o}, 64'd0);
            check("rst_data", {32'd0, rom_w_data_o}, 64'd0);
            check("rst_flags", {60'd0, load_busy_o, load_done_o, frame_err_o, chk_err_o}, 64'h8);
        end
        rst = 1'b0;
        wr_q.delete();
        good_q.delete();
        bad_sent = 1'b0;
        repeat (2 * DIV) @(posedge clk);
    endtask

    // Reference: interpret the accepted bytes as length, words, optional checksum, then ignore the rest.
    task automatic verify(input string name);
        logic [63:0] exp_q[$];
        logic [15:0] n;
        logic [31:0] word;
        logic [7:0]  x;
        logic        done, cerr;
        int          k;
        repeat (5 * DIV) @(posedge clk);
        @(negedge clk);
        n = 16'd0; x = 8'd0; done = 1'b0; cerr = 1'b0; k = 2;
        if (good_q.size() >= 2) begin
            n = {good_q[1], good_q[0]};
            done = 1'b1;
            for (int w = 0; w < int'(n); w++) begin
                if (k + 4 > good_q.size()) begin
                    done = 1'b0;
                    break;
                end
                word = {good_q[k+3], good_q[k+2], good_q[k+1], good_q[k]};
                x = x ^ good_q[k] ^ good_q[k+1] ^ good_q[k+2] ^ good_q[k+3];
                exp_q.push_back({32'(4 * w), word});
                k += 4;
            end
`ifdef LOADER_CHECKSUM_EN
            if (done) begin
                if (k < good_q.size()) cerr = good_q[k] != x;
                else done = 1'b0;
            end
`endif
        end
        check($sformatf("%s wr_count", name), 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check($sformatf("%s wr%0d", name, i), wr_q[i], exp_q[i]);
        check($sformatf("%s done_busy", name), {62'd0, load_done_o, load_busy_o}, {62'd0, done, !done});
        check($sformatf("%s frame_err", name), {63'd0, frame_err_o}, {63'd0, bad_sent});
        check($sformatf("%s chk_err", name), {63'd0, chk_err_o}, {63'd0, cerr});
    endtask

    initial begin
        logic [7:0] b, x;
        int         n;
        do_reset(1'b1);

        stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        stream_q.push_back(8'h7C);
`endif
        send_stream();
        verify("two_words");
        if (wr_q.size() == 2) begin
            check("two_words w0", wr_q[0], {32'd0, 32'h13});
            check("two_words w1", wr_q[1], {32'd4, 32'h6F});
        end
        check("two_words done", {63'd0, load_done_o}, 64'd1);

`ifdef LOADER_CHECKSUM_EN
        do_reset(1'b0);
        stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7D};
        send_stream();
        verify("bad_chk");
        check("bad_chk flags", {62'd0, chk_err_o, load_done_o}, 64'h3);
`endif

        do_reset(1'b0);
        stream_q = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        stream_q.push_back(8'h00);
`endif
        send_stream();
        verify("zero_len");
        check("zero_len nowr", 64'(wr_q.size()), 64'd0);

        do_reset(1'b0);
        stream_q = '{8'h01, 8'h00};
        send_stream();
        send_byte(8'h13, 1'b0);
        @(negedge clk);
        check("frame_err set", {63'd0, frame_err_o}, 64'd1);
        stream_q = '{8'h13, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        stream_q.push_back(8'h13);
`endif
        send_stream();
        verify("frame_err");
        if (wr_q.size() == 1) check("frame_err w0", wr_q[0], {32'd0, 32'h13});

        do_reset(1'b0);
        uart_rxd = 1'b0;
        repeat (3) @(posedge clk);
        uart_rxd = 1'b1;
        repeat (3 * DIV) @(posedge clk);
        stream_q = '{8'h01, 8'h00, 8'hA5, 8'h5A, 8'h3C, 8'hC3};
`ifdef LOADER_CHECKSUM_EN
        stream_q.push_back(8'h00);
`endif
        send_stream();
        verify("glitch");

        do_reset(1'b0);
        stream_q = '{8'h02, 8'h00, 8'h13, 8'h00};
        send_stream();
        do_reset(1'b1);
        stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        stream_q.push_back(8'h7C);
`endif
        send_stream();
        verify("mid_rst");
        if (wr_q.size() > 0) check("mid_rst w0", wr_q[0], {32'd0, 32'h13});

        for (int it = 0; it < 6; it++) begin
            do_reset(1'b0);
            n = $urandom_range(1, 4);
            x = 8'd0;
            stream_q.push_back(8'(n));
            stream_q.push_back(8'h00);
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                x ^= b;
                stream_q.push_back(b);
            end
`ifdef LOADER_CHECKSUM_EN
            stream_q.push_back(($urandom_range(0, 1) == 1) ? x : x ^ 8'h01);
`endif
            stream_q.push_back(8'($urandom));
            stream_q.push_back(8'($urandom));
            foreach (stream_q[i]) begin
                if ($urandom_range(0, 5) == 0) send_byte(8'($urandom), 1'b0);
                send_byte(stream_q[i], 1'b1);
            end
            stream_q.delete();
            verify($sformatf("rand%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rom_loader.md
UART_ROM_LOADER -- requirements
Module: uart_rom_loader

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate; DIV = CLK_FREQ/BAUD, integer division.
REQ-003 SHALL have port clk  input  1  the single system clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port uart_rxd  input  1  serial receive line, idle high, asynchronous to clk.
REQ-006 SHALL have port rom_w_en_o  output  1  one-cycle ROM write strobe.
REQ-007 SHALL have port rom_w_addr_o  output  32  ROM byte address of the current write.
REQ-008 SHALL have port rom_w_data_o  output  32  ROM write word.
REQ-009 SHALL have port load_busy_o  output  1  high while the load is in progress; holds the core in reset.
REQ-010 SHALL have port load_done_o  output  1  high once the image is fully written; sticky until reset.
REQ-011 SHALL have port frame_err_o  output  1  sticky flag: a stop bit was sampled low.
REQ-012 SHALL have port chk_err_o  output  1  sticky flag: checksum mismatch (see Configuration).

Function
REQ-013 SHALL pass uart_rxd through a two-flop synchronizer before any use.
REQ-014 Receiver FSM SHALL have states RX_IDLE, RX_START, RX_DATA and RX_STOP.
REQ-015 RX_IDLE->RX_START SHALL occur on a synchronized falling edge of the line.
REQ-016 RX_START SHALL sample the line at DIV/2 cycles; high = glitch, return to RX_IDLE; low = go to RX_DATA.
REQ-017 RX_DATA SHALL sample 8 bits at DIV-cycle intervals, LSB first.
REQ-018 RX_STOP SHALL sample the stop bit after a further DIV cycles, then return to RX_IDLE.
REQ-019 Stop bit high: the byte SHALL be delivered as a one-cycle internal byte_valid pulse.
REQ-020 Stop bit low: the byte SHALL be discarded and frame_err_o set.
REQ-021 Loader FSM SHALL have states LD_LEN_LO, LD_LEN_HI, LD_WORD, LD_CHK and LD_DONE.
REQ-022 Loader FSM SHALL advance only on byte_valid.
REQ-023 LD_LEN_LO and LD_LEN_HI SHALL capture the word count N[15:0], little-endian.
REQ-024 N=0 SHALL go directly from LD_LEN_HI to LD_DONE (or to LD_CHK when the macro is defined).
REQ-025 LD_WORD SHALL assemble 4 bytes little-endian, first byte into bits [7:0].
REQ-026 rom_w_en_o SHALL pulse in the cycle after the 4th byte's byte_valid, with rom_w_data_o holding the assembled word.
REQ-027 rom_w_addr_o SHALL be 0 for the first word and increment by 4 after each write.
REQ-028 After the Nth write the loader SHALL enter LD_CHK (macro defined) or LD_DONE.
REQ-029 rom_w_en_o SHALL never be high for two consecutive cycles.
REQ-030 load_busy_o SHALL be high from reset release until LD_DONE is entered.
REQ-031 load_done_o SHALL rise in the same cycle load_busy_o falls.
REQ-032 In LD_DONE all received bytes SHALL be ignored and no further writes SHALL occur until reset.
REQ-033 A framing error SHALL NOT advance or abort the loader; the next good byte is taken as the next expected byte.

Reset
REQ-034 rst high SHALL immediately force both FSMs to RX_IDLE and LD_LEN_LO and clear all counters and the assembly register.
REQ-035 Under rst: rom_w_en_o=0, rom_w_addr_o=0, rom_w_data_o=0, load_busy_o=1, load_done_o=0, frame_err_o=0, chk_err_o=0.
REQ-036 Reset asserted mid-byte or mid-word SHALL discard the partial data; the load restarts from LD_LEN_LO.

Configuration
REQ-037 Macro LOADER_CHECKSUM_EN defined: after the last word, LD_CHK SHALL receive one byte and compare it with the XOR of all data bytes (length bytes excluded).
REQ-038 With LOADER_CHECKSUM_EN, a mismatch SHALL set chk_err_o; LD_DONE is entered either way.
REQ-039 Macro LOADER_CHECKSUM_EN undefined: LD_CHK and the XOR logic SHALL be absent and chk_err_o SHALL be tied to 0.

Verification
REQ-040 CLK_FREQ=1000000, BAUD=100000 (DIV=10); send 02 00 13 00 00 00 6F 00 00 00 -> writes (addr 0, 0x00000013) then (addr 4, 0x0000006F); load_done_o=1; load_busy_o=0.
REQ-041 Same stream plus checksum byte 0x7C, macro defined -> chk_err_o=0; with 0x7D -> chk_err_o=1 and load_done_o=1.
REQ-042 Send 00 00 (N=0), macro undefined -> no rom_w_en_o pulse; load_done_o=1 after the second stop bit.
REQ-043 Byte 0x13 sent with stop bit low -> frame_err_o=1, no byte consumed; a resend of 0x13 completes the word normally.
REQ-044 3-cycle low glitch on uart_rxd in RX_IDLE -> no byte_valid, loader state unchanged.
REQ-045 rst pulse after 2 of the 4 bytes of word 1 -> all outputs return to reset values; a full resend loads correctly from addr 0.
